// File: rtl/gaussian_stage_ctrl_pkg.sv
// Shared definitions for the Gaussian blur stage controller: FSM state encoding,
// default pixel width and small state-decode helpers.
// Latency: n/a (definitions only). Backpressure: n/a.
package gaussian_stage_ctrl_pkg;

  localparam int PIX_W_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRIME = 3'd1,
    ST_RUN   = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Frame in flight: the stage owns the filter and both FIFOs.
  function automatic logic state_busy(input state_e s);
    return (s == ST_PRIME) || (s == ST_RUN) || (s == ST_FLUSH);
  endfunction

  // States in which the filter is fed from the source FIFO (not zero-drained).
  function automatic logic state_feeding(input state_e s);
    return (s == ST_PRIME) || (s == ST_RUN);
  endfunction

endpackage

// File: rtl/gaussian_stage_ctrl_if.sv
// Data-path bundle around the stage controller: source FIFO read side (FWFT),
// Gaussian filter feed/enable/result, destination FIFO write side.
// master = controller side (drives pops, filter enable, writes); slave = environment side.
interface gaussian_stage_ctrl_if
  import gaussian_stage_ctrl_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF
);
  // source FIFO, first-word-fall-through
  logic             in_valid;
  logic [PIX_W-1:0] in_data;
  logic             in_rd_en;
  // Gaussian filter
  logic [PIX_W-1:0] g_din;
  logic             g_clk_en;
  logic [PIX_W-1:0] g_dout;
  // destination FIFO
  logic             out_full;
  logic             out_wr_en;
  logic [PIX_W-1:0] out_din;

  modport master (
    input  in_valid, in_data, g_dout, out_full,
    output in_rd_en, g_din, g_clk_en, out_wr_en, out_din
  );

  modport slave (
    output in_valid, in_data, g_dout, out_full,
    input  in_rd_en, g_din, g_clk_en, out_wr_en, out_din
  );

endinterface

// File: rtl/gaussian_stage_ctrl_frame_counter.sv
// Frame-scoped up-counter with synchronous clear and terminal-value flags.
// Latency: count updates one cycle after en; last/past are combinational from the count.
// Backpressure: none; the caller gates en.
//   clk, rst : clock, async active-high reset
//   clr      : synchronous clear (wins over en)
//   en       : count one event this cycle
//   last     : this enabled event brings the count to TERM
//   past     : count has already reached TERM
module gaussian_stage_ctrl_frame_counter
  import gaussian_stage_ctrl_pkg::*;
#(
  parameter int CNT_W = 20,
  parameter int TERM  = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last,
  output logic past
);

  localparam logic [CNT_W-1:0] TERM_C  = CNT_W'(TERM);
  localparam logic [CNT_W-1:0] TERM_M1 = CNT_W'(TERM - 1);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = en & (cnt_q == TERM_M1);
  assign past = (cnt_q >= TERM_C);

endmodule

// File: rtl/gaussian_stage_ctrl.sv
// Sequences one Gaussian blur stage over a frame: pops the source FIFO, clock-enables the
// filter, hides the priming outputs, then drains the filter with zeros.
// Latency: strobes are combinational in the advance cycle; busy/frame_done are registered.
// Backpressure: out_full stalls source and filter together after priming; empty source stalls PRIME/RUN.
//   clk, rst           : clock, async active-high reset
//   start / abort      : begin a frame (IDLE only) / synchronous return to IDLE
//   busy / frame_done  : frame in flight / one-cycle pulse after the last write
//   io (master)        : source FIFO read, filter feed/enable/result, destination FIFO write
module gaussian_stage_ctrl
  import gaussian_stage_ctrl_pkg::*;
#(
  parameter int PIX_W       = PIX_W_DEF,
  parameter int IMG_W       = 640,
  parameter int IMG_H       = 480,
  parameter int PRIME_DEPTH = 1612,
  parameter int CNT_W       = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  frame_done,
  gaussian_stage_ctrl_if.master io
);

  // Configuration must satisfy TOTAL > PRIME_DEPTH >= 1 and CNT_W must hold
  // TOTAL + PRIME_DEPTH, or the RUN phase and the advance count break.
  localparam int TOTAL = IMG_W * IMG_H;
  localparam logic [PIX_W-1:0] PIX_ZERO = '0;

  state_e state_q, state_d;
  logic   busy_q, busy_d;
  logic   frame_done_q, frame_done_d;

  logic feeding;
  logic adv, pop, wr;
  logic start_acc, cnt_clr;
  logic adv_last, adv_past;
  logic in_last, in_past;
  logic out_last, out_past;

  // Advance strobe and the pop/write strobes derived from it.
  always_comb begin
    feeding = state_feeding(state_q);
    adv     = 1'b0;
    case (state_q)
      ST_PRIME: adv = io.in_valid;                  // nothing is written yet, so out_full is irrelevant
      ST_RUN:   adv = io.in_valid & ~io.out_full;
      ST_FLUSH: adv = ~io.out_full;                 // zero drain, independent of the source
      default:  adv = 1'b0;
    endcase
    // in_past/out_past can only be set here if the count ever overran; they keep the
    // FIFOs safe from an extra pop or write rather than shaping normal operation.
    pop = adv & feeding & ~in_past;
    // Filter output is meaningful once PRIME_DEPTH advances have filled its line buffers;
    // the write rides on the same advance that shifts the filter.
    wr  = adv & adv_past & ~out_past;
  end

  assign io.g_clk_en  = adv;
  assign io.in_rd_en  = pop;
  assign io.g_din     = feeding ? io.in_data : PIX_ZERO;
  assign io.out_wr_en = wr;
  assign io.out_din   = io.g_dout;

  // Next state and registered status outputs.
  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_PRIME;
          start_acc = 1'b1;
        end
      end
      ST_PRIME: if (adv_last) state_d = ST_RUN;
      ST_RUN:   if (in_last)  state_d = ST_FLUSH;
      ST_FLUSH: if (out_last) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;                  // start here is not accepted
      default:  state_d = ST_IDLE;
    endcase
    // abort overrides every transition, including entry to DONE and a start in IDLE.
    if (abort) begin
      state_d   = ST_IDLE;
      start_acc = 1'b0;
    end
    cnt_clr      = start_acc | abort;
    busy_d       = state_busy(state_d);
    frame_done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign busy       = busy_q;
  assign frame_done = frame_done_q;

  // Filter advances: PRIME ends on the advance that reaches PRIME_DEPTH.
  gaussian_stage_ctrl_frame_counter #(.CNT_W(CNT_W), .TERM(PRIME_DEPTH)) u_adv_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (adv),
    .last (adv_last),
    .past (adv_past)
  );

  // Source pops: RUN ends on the pop that reaches TOTAL.
  gaussian_stage_ctrl_frame_counter #(.CNT_W(CNT_W), .TERM(TOTAL)) u_in_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (pop),
    .last (in_last),
    .past (in_past)
  );

  // Destination writes: FLUSH ends on the write that reaches TOTAL.
  gaussian_stage_ctrl_frame_counter #(.CNT_W(CNT_W), .TERM(TOTAL)) u_out_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (wr),
    .last (out_last),
    .past (out_past)
  );

endmodule

// File: tb/tb_gaussian_stage_ctrl.sv
// Directed bench for gaussian_stage_ctrl with an 8x4 frame and a 5-deep filter delay line.
module tb_gaussian_stage_ctrl;

  localparam int PIX_W = 8;
  localparam int IMG_W = 8;
  localparam int IMG_H = 4;
  localparam int TOTAL = 32;
  localparam int PRIME = 5;
  localparam int CNT_W = 20;

  logic clk = 1'b0;
  logic rst, start, abort;
  logic busy, frame_done;

  gaussian_stage_ctrl_if #(.PIX_W(PIX_W)) io ();

  gaussian_stage_ctrl #(
    .PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .PRIME_DEPTH(PRIME), .CNT_W(CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .busy       (busy),
    .frame_done (frame_done),
    .io         (io)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [PIX_W-1:0] src_q[$];
  logic [PIX_W-1:0] pop_log[$];
  logic [PIX_W-1:0] out_log[$];
  logic [PIX_W-1:0] filt[PRIME];
  logic [PIX_W-1:0] next_pix;

  int  adv_n, pop_n, wr_n, done_n, fl_n, first_wr_adv, viol;
  bit  vld_gate, full_gate;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) begin
      src_q.push_back(next_pix);
      next_pix = next_pix + 8'd1;
    end
  endtask

  task automatic clr_frame();
    adv_n = 0; pop_n = 0; wr_n = 0; done_n = 0; fl_n = 0; first_wr_adv = 0; viol = 0;
    pop_log.delete();
    out_log.delete();
  endtask

  // One clock: drive inputs at negedge, observe strobes before the posedge and
  // advance the FIFO / filter models exactly as the upcoming edge will.
  task automatic step(input bit st, input bit ab);
    @(negedge clk);
    start       = st;
    abort       = ab;
    io.in_valid = vld_gate && (src_q.size() > 0);
    io.in_data  = (src_q.size() > 0) ? src_q[0] : '0;
    io.g_dout   = filt[PRIME-1];
    io.out_full = full_gate;
    #2;
    if (io.in_rd_en && !io.in_valid) viol++;
    if (io.in_rd_en !== (io.g_clk_en && pop_n < TOTAL)) viol++;
    if (io.out_wr_en !== (io.g_clk_en && adv_n >= PRIME)) viol++;
    if (io.g_clk_en && io.out_full && adv_n >= PRIME) viol++;
    if (io.g_clk_en && pop_n < TOTAL && !io.in_valid) viol++;
    if (io.g_clk_en && pop_n < TOTAL && io.g_din !== io.in_data) viol++;
    if (io.g_clk_en && pop_n >= TOTAL && io.g_din !== '0) viol++;
    if (io.out_wr_en && io.out_din !== io.g_dout) viol++;
    if (io.in_rd_en && src_q.size() > 0) begin
      pop_log.push_back(src_q.pop_front());
      pop_n++;
    end
    if (io.out_wr_en) begin
      out_log.push_back(io.out_din);
      wr_n++;
      if (wr_n == 1) first_wr_adv = adv_n + 1;
    end
    if (io.g_clk_en) begin
      if (pop_n >= TOTAL && !io.in_rd_en) fl_n++;
      for (int i = PRIME - 1; i > 0; i--) filt[i] = filt[i-1];
      filt[0] = io.g_din;
      adv_n++;
    end
    if (frame_done) done_n++;
  endtask

  task automatic run_frame(input bit bp, input bit starve, input int restart_at, output int cyc);
    int hold_a, hold_b;
    bit st;
    hold_a = 0; hold_b = 0;
    clr_frame();
    vld_gate  = 1'b1;
    full_gate = 1'b0;
    step(1'b1, 1'b0);
    cyc = 0;
    while (done_n == 0 && cyc < 300) begin
      full_gate = bp && (adv_n < PRIME || (adv_n == 19 && hold_a < 10) || (adv_n == 33 && hold_b < 10));
      if (full_gate && adv_n == 19) hold_a++;
      if (full_gate && adv_n == 33) hold_b++;
      vld_gate = !starve || (pop_n < TOTAL && (cyc % 2) == 1);
      st = (restart_at > 0 && cyc == restart_at);
      step(st, 1'b0);
      cyc++;
    end
    full_gate = 1'b0;
    vld_gate  = 1'b1;
  endtask

  task automatic check_frame(input string pfx, input int cyc, input int exp_cyc);
    int m;
    m = 0;
    for (int i = 0; i < out_log.size() && i < pop_log.size(); i++)
      if (out_log[i] !== pop_log[i]) m++;
    chk_eq({pfx, "_adv"},      adv_n, TOTAL + PRIME);
    chk_eq({pfx, "_pops"},     pop_n, TOTAL);
    chk_eq({pfx, "_writes"},   wr_n, TOTAL);
    chk_eq({pfx, "_flush_adv"}, fl_n, PRIME);
    chk_eq({pfx, "_first_wr"}, first_wr_adv, PRIME + 1);
    chk_eq({pfx, "_cycles"},   cyc, exp_cyc);
    chk_eq({pfx, "_protocol"}, viol, 0);
    chk_eq({pfx, "_data"},     m, 0);
    step(1'b0, 1'b0);
    chk_eq({pfx, "_done_cnt"}, done_n, 1);
    chk_eq({pfx, "_busy_end"}, busy, 1'b0);
    chk_eq({pfx, "_done_low"}, frame_done, 1'b0);
  endtask

  int cyc, a0, k;
  logic [PIX_W-1:0] head;

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    io.in_valid = 1'b1; io.in_data = '0; io.g_dout = '0; io.out_full = 1'b0;
    vld_gate = 1'b1; full_gate = 1'b0; next_pix = 8'd1;
    for (int i = 0; i < PRIME; i++) filt[i] = '0;
    clr_frame();

    // Reset state, with a pixel already presented.
    repeat (2) @(negedge clk);
    #1;
    chk_eq("rst_busy",      busy, 1'b0);
    chk_eq("rst_done",      frame_done, 1'b0);
    chk_eq("rst_rd_en",     io.in_rd_en, 1'b0);
    chk_eq("rst_g_clk_en",  io.g_clk_en, 1'b0);
    chk_eq("rst_wr_en",     io.out_wr_en, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // 1. Reset asserted mid-frame in RUN.
    fill(32);
    clr_frame();
    step(1'b1, 1'b0);
    k = 0;
    while (pop_n < 12 && k < 100) begin step(1'b0, 1'b0); k++; end
    chk_eq("t1_busy_run", busy, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    io.in_valid = 1'b1;
    #1;
    chk_eq("t1_busy",  busy, 1'b0);
    chk_eq("t1_done",  frame_done, 1'b0);
    chk_eq("t1_rd_en", io.in_rd_en, 1'b0);
    chk_eq("t1_wr_en", io.out_wr_en, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    a0 = adv_n;
    repeat (3) step(1'b0, 1'b0);
    chk_eq("t1_idle_no_adv", adv_n, a0);
    chk_eq("t1_idle_busy",   busy, 1'b0);
    src_q.delete();

    // 2. Streaming frame.
    next_pix = 8'd1;
    fill(32);
    run_frame(1'b0, 1'b0, 0, cyc);
    chk_eq("t2_first_pop", (pop_log.size() > 0) ? pop_log[0] : 8'hFF, 8'd1);
    chk_eq("t2_last_out",  (out_log.size() == 32) ? out_log[31] : 8'hFF, 8'd32);
    check_frame("t2", cyc, 38);

    // 3. Backpressure in PRIME (no effect), RUN and FLUSH (10 cycles each).
    fill(32);
    run_frame(1'b1, 1'b0, 0, cyc);
    check_frame("t3", cyc, 58);

    // 4. Source alternating valid/empty in PRIME/RUN, empty through FLUSH.
    fill(32);
    run_frame(1'b0, 1'b1, 0, cyc);
    check_frame("t4", cyc, 70);

    // 5. Abort in FLUSH, then a full frame with a stray start mid-frame.
    fill(32);
    clr_frame();
    step(1'b1, 1'b0);
    k = 0;
    while (adv_n < 34 && k < 100) begin step(1'b0, 1'b0); k++; end
    chk_eq("t5_in_flush", pop_n, 32);
    step(1'b0, 1'b1);
    a0 = adv_n;
    repeat (3) step(1'b0, 1'b0);
    chk_eq("t5_abort_busy",  busy, 1'b0);
    chk_eq("t5_abort_nodone", done_n, 0);
    chk_eq("t5_abort_noadv", adv_n, a0);
    src_q.delete();
    fill(32);
    run_frame(1'b0, 1'b0, 10, cyc);
    check_frame("t5b", cyc, 38);

    // 6. Surplus input: 40 queued, 32 consumed, leftovers lead the next frame.
    src_q.delete();
    next_pix = 8'd100;
    fill(40);
    run_frame(1'b0, 1'b0, 0, cyc);
    check_frame("t6a", cyc, 38);
    chk_eq("t6_left", src_q.size(), 8);
    head = (src_q.size() > 0) ? src_q[0] : 8'hFF;
    chk_eq("t6_left_head", head, 8'd132);
    fill(24);
    run_frame(1'b0, 1'b0, 0, cyc);
    chk_eq("t6_next_first", (pop_log.size() > 0) ? pop_log[0] : 8'hFF, 8'd132);
    check_frame("t6b", cyc, 38);
    chk_eq("t6_drained", src_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d compared so far", n_cmp);
    $fatal(1);
  end

endmodule
